sha1_core_iter: RTL and testbench



---
 rtl/sha1_pkg.sv | 54 +++++
 rtl/sha1_round.sv | 40 ++++
 rtl/sha1_core_iter.sv | 158 +++++++++++++++
 tb/tb_sha1_core_iter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, state types and round helper functions.
// Imported by the iterative core and by the single-round datapath slice.
package sha1_pkg;

    localparam logic [31:0] H0_INIT = 32'h67452301;
    localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
    localparam logic [31:0] H2_INIT = 32'h98BADCFE;
    localparam logic [31:0] H3_INIT = 32'h10325476;
    localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        UPDATE = 2'd2
    } sha1_fsm_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_state_t;

    localparam sha1_state_t IV_STATE = {H0_INIT, H1_INIT, H2_INIT, H3_INIT, H4_INIT};

    // Upper half of the doubled word shifted left is the left rotation.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {x, x} << n;
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] f_ch(input logic [31:0] b, input logic [31:0] c,
                                         input logic [31:0] d);
        return (b & c) | (~b & d);
    endfunction

    function automatic logic [31:0] f_parity(input logic [31:0] b, input logic [31:0] c,
                                             input logic [31:0] d);
        return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] f_maj(input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] d);
        return (b & c) | (b & d) | (c & d);
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 compression round; the core chains several of these
// per clock to trade clock rate for latency.
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_state_t st,
    input  logic [6:0]  idx,
    input  logic [31:0] w,
    output sha1_state_t st_next
);

    logic [31:0] f;
    logic [31:0] k;
    logic [31:0] temp;

    always_comb begin
        if (idx < 7'd20) begin
            f = f_ch(st.b, st.c, st.d);
            k = K0;
        end else if (idx < 7'd40) begin
            f = f_parity(st.b, st.c, st.d);
            k = K1;
        end else if (idx < 7'd60) begin
            f = f_maj(st.b, st.c, st.d);
            k = K2;
        end else begin
            f = f_parity(st.b, st.c, st.d);
            k = K3;
        end

        temp = rotl32(st.a, 5'd5) + f + st.e + k + w;

        st_next.a = temp;
        st_next.b = st.a;
        st_next.c = rotl32(st.b, 5'd30);
        st_next.d = st.c;
        st_next.e = st.d;
    end

endmodule

// File: rtl/sha1_core_iter.sv
// Iterative multi-block SHA-1 engine: accepts pre-padded 512-bit blocks,
// runs ROUNDS_PER_CYCLE rounds per clock and chains H across blocks.
module sha1_core_iter
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         busy,
    output logic         digest_valid,
    output logic [159:0] digest
);

    localparam int R  = ROUNDS_PER_CYCLE;
    localparam int NX = R + 16;

    if (!(R == 1 || R == 2 || R == 4 || R == 5 || R == 8 ||
          R == 10 || R == 16 || R == 20)) begin : g_bad_rpc
        $error("sha1_core_iter: ROUNDS_PER_CYCLE must divide 80 and be at most 20");
    end

    sha1_fsm_t   state;
    logic [6:0]  rnd;
    logic        last_q;
    logic        pub_q;
    sha1_state_t hq;
    sha1_state_t work;
    sha1_state_t h_sum;
    sha1_state_t round_out;
    logic [31:0] win     [16];
    logic [31:0] win_nxt [16];
    logic        accept;
    logic        round_done;

    assign accept     = (state == IDLE) && blk_ready && blk_valid;
    assign round_done = (rnd + 7'(R)) == 7'd80;

    // Rolling schedule: the window holds W[t..t+15]; extend it far enough to
    // feed every round of this cycle and to refill the window for the next.
    for (genvar i = 0; i < NX; i++) begin : g_ext
        logic [31:0] wx;
        if (i < 16) begin : g_win
            assign wx = win[i];
        end else begin : g_gen
            assign wx = rotl32(g_ext[i-3].wx ^ g_ext[i-8].wx ^
                               g_ext[i-14].wx ^ g_ext[i-16].wx, 5'd1);
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_wnext
        assign win_nxt[i] = g_ext[i+R].wx;
    end

    for (genvar j = 0; j < R; j++) begin : g_rnd
        sha1_state_t st_in;
        sha1_state_t st_out;
        if (j == 0) begin : g_head
            assign st_in = work;
        end else begin : g_link
            assign st_in = g_rnd[j-1].st_out;
        end
        sha1_round u_round (
            .st      (st_in),
            .idx     (rnd + 7'(j)),
            .w       (g_ext[j].wx),
            .st_next (st_out)
        );
    end

    assign round_out = g_rnd[R-1].st_out;

    assign h_sum.a = hq.a + work.a;
    assign h_sum.b = hq.b + work.b;
    assign h_sum.c = hq.c + work.c;
    assign h_sum.d = hq.d + work.d;
    assign h_sum.e = hq.e + work.e;

    // Working variables and schedule window carry no meaning outside a
    // block in flight, so they are loaded on accept rather than reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= blk_data[511-32*i -: 32];
            end
            work <= blk_first ? IV_STATE : hq;
        end else if (state == ROUND) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= win_nxt[i];
            end
            work <= round_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            blk_ready    <= 1'b0;
            busy         <= 1'b0;
            rnd          <= 7'd0;
            last_q       <= 1'b0;
            pub_q        <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
            hq           <= IV_STATE;
        end else begin
            // Publish one cycle after UPDATE so the digest comes from the settled H.
            digest_valid <= pub_q;
            pub_q        <= 1'b0;
            if (pub_q) begin
                digest <= hq;
            end

            case (state)
                IDLE: begin
                    blk_ready <= 1'b1;
                    if (accept) begin
                        state     <= ROUND;
                        blk_ready <= 1'b0;
                        busy      <= 1'b1;
                        rnd       <= 7'd0;
                        last_q    <= blk_last;
                        if (blk_first) begin
                            hq <= IV_STATE;
                        end
                    end
                end
                ROUND: begin
                    if (round_done) begin
                        state <= UPDATE;
                        rnd   <= 7'd0;
                    end else begin
                        rnd <= rnd + 7'(R);
                    end
                end
                UPDATE: begin
                    hq        <= h_sum;
                    pub_q     <= last_q;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    blk_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    blk_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_core_iter.sv
// Bench for sha1_core_iter: three cores (1, 4 and 20 rounds per clock) checked
// every cycle against a plain 80-word SHA-1 compression model.
module tb_sha1_core_iter;

    localparam logic [159:0] IV        = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] ABC_DIG   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] EMPTY_DIG = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0]          vld = '0;
    logic [2:0]          fst = '0;
    logic [2:0]          lst = '0;
    logic [2:0][511:0]   data = '0;
    logic [2:0]          rdy;
    logic [2:0]          bsy;
    logic [2:0]          dv;
    logic [2:0][159:0]   dig;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    int acc_cyc   [3];
    int pulse_cyc [3];
    int pulse_cnt [3];
    logic [159:0] hm      [3];
    logic [159:0] exp_dig [3];
    int wst  [3];
    int wend [3];
    int q_cyc [3][$];
    logic [159:0] q_dig [3][$];
    bit edv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sha1_core_iter #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .blk_valid(vld[0]), .blk_ready(rdy[0]),
        .blk_data(data[0]), .blk_first(fst[0]), .blk_last(lst[0]), .busy(bsy[0]),
        .digest_valid(dv[0]), .digest(dig[0]));
    sha1_core_iter #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .blk_valid(vld[1]), .blk_ready(rdy[1]),
        .blk_data(data[1]), .blk_first(fst[1]), .blk_last(lst[1]), .busy(bsy[1]),
        .digest_valid(dv[1]), .digest(dig[1]));
    sha1_core_iter #(.ROUNDS_PER_CYCLE(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .blk_valid(vld[2]), .blk_ready(rdy[2]),
        .blk_data(data[2]), .blk_first(fst[2]), .blk_last(lst[2]), .busy(bsy[2]),
        .digest_valid(dv[2]), .digest(dig[2]));

    function automatic int ncyc(input int g);
        return (g == 0) ? 80 : (g == 1) ? 20 : 4;
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [159:0] sha1_compress(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        {a, b, c, d, e} = hin;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = rol(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rol(b, 30); b = a; a = t;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    task automatic check(input bit ok, input string nm, input logic [159:0] act,
                         input logic [159:0] expv);
        ntests++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Single compare process: every cycle, every lane.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                hm[g] = IV;
                exp_dig[g] = '0;
                q_cyc[g].delete();
                q_dig[g].delete();
                wst[g] = 0;
                wend[g] = -1;
                check(dv[g] == 1'b0, $sformatf("lane%0d reset digest_valid", g), 160'(dv[g]), 160'd0);
                check(bsy[g] == 1'b0, $sformatf("lane%0d reset busy", g), 160'(bsy[g]), 160'd0);
                check(rdy[g] == 1'b0, $sformatf("lane%0d reset blk_ready", g), 160'(rdy[g]), 160'd0);
                check(dig[g] == 160'd0, $sformatf("lane%0d reset digest", g), dig[g], 160'd0);
            end else begin
                edv = 1'b0;
                if (q_cyc[g].size() > 0 && q_cyc[g][0] == cyc) begin
                    edv = 1'b1;
                    exp_dig[g] = q_dig[g][0];
                    void'(q_cyc[g].pop_front());
                    void'(q_dig[g].pop_front());
                end
                check(dv[g] == edv, $sformatf("lane%0d digest_valid cyc%0d", g, cyc),
                      160'(dv[g]), 160'(edv));
                check(dig[g] == exp_dig[g], $sformatf("lane%0d digest cyc%0d", g, cyc),
                      dig[g], exp_dig[g]);
                check(bsy[g] == (cyc >= wst[g] && cyc <= wend[g]),
                      $sformatf("lane%0d busy cyc%0d", g, cyc), 160'(bsy[g]),
                      160'(cyc >= wst[g] && cyc <= wend[g]));
                if (cyc >= wst[g] && cyc <= wend[g])
                    check(rdy[g] == 1'b0, $sformatf("lane%0d blk_ready in flight", g),
                          160'(rdy[g]), 160'd0);
                if (dv[g]) begin
                    pulse_cyc[g] = cyc;
                    pulse_cnt[g]++;
                end
                if (vld[g] && rdy[g]) begin
                    acc_cyc[g] = cyc + 1;
                    wst[g] = cyc + 1;
                    wend[g] = cyc + 1 + ncyc(g);
                    if (fst[g]) hm[g] = IV;
                    hm[g] = sha1_compress(hm[g], data[g]);
                    if (lst[g]) begin
                        q_cyc[g].push_back(cyc + 1 + ncyc(g) + 2);
                        q_dig[g].push_back(hm[g]);
                    end
                end
            end
        end
    end

    task automatic send(input int ln, input logic [511:0] b, input bit f, input bit l, input bit keep);
        bit got;
        got = 1'b0;
        data[ln] = b; fst[ln] = f; lst[ln] = l; vld[ln] = 1'b1;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (rdy[ln]) got = 1'b1;
            @(posedge clk); #1;
        end
        if (!keep) vld[ln] = 1'b0;
        check(got, $sformatf("lane%0d send accepted", ln), 160'(got), 160'd1);
    endtask

    task automatic wait_pulses(input int ln, input int target);
        for (int n = 0; n < 400; n++) begin
            if (pulse_cnt[ln] >= target) break;
            @(posedge clk);
        end
        #1;
        check(pulse_cnt[ln] >= target, $sformatf("lane%0d pulse timeout", ln),
              160'(pulse_cnt[ln]), 160'(target));
    endtask

    logic [511:0] abc_blk, empty_blk;
    logic [511:0] mb [3];
    logic [159:0] mb_exp;
    int base;

    initial begin
        for (int g = 0; g < 3; g++) begin
            acc_cyc[g] = 0; pulse_cyc[g] = 0; pulse_cnt[g] = 0;
            hm[g] = IV; exp_dig[g] = '0; wst[g] = 0; wend[g] = -1;
        end
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0] = 32'h00000018;
        empty_blk = '0;
        empty_blk[511:480] = 32'h80000000;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 16; i++) mb[b][511-32*i -: 32] = $urandom;
        mb_exp = IV;
        for (int b = 0; b < 3; b++) mb_exp = sha1_compress(mb_exp, mb[b]);

        check(sha1_compress(IV, abc_blk) == ABC_DIG, "model abc", sha1_compress(IV, abc_blk), ABC_DIG);
        check(sha1_compress(IV, empty_blk) == EMPTY_DIG, "model empty",
              sha1_compress(IV, empty_blk), EMPTY_DIG);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Lane 0 (1 round per clock)
        send(0, abc_blk, 1, 1, 0);
        wait_pulses(0, 1);
        check(dig[0] == ABC_DIG, "abc digest r1", dig[0], ABC_DIG);
        check(pulse_cyc[0] - acc_cyc[0] == 82, "abc latency r1",
              160'(pulse_cyc[0] - acc_cyc[0]), 160'd82);

        send(0, empty_blk, 1, 1, 0);
        wait_pulses(0, 2);
        check(dig[0] == EMPTY_DIG, "empty digest", dig[0], EMPTY_DIG);

        base = pulse_cnt[0];
        send(0, mb[0], 1, 0, 0);
        send(0, mb[1], 0, 0, 0);
        send(0, mb[2], 0, 1, 0);
        wait_pulses(0, base + 1);
        repeat (4) @(posedge clk);
        #1;
        check(dig[0] == mb_exp, "multiblock digest r1", dig[0], mb_exp);
        check(pulse_cnt[0] == base + 1, "multiblock pulse count r1", 160'(pulse_cnt[0]), 160'(base + 1));

        base = pulse_cnt[0];
        send(0, abc_blk, 1, 1, 1);
        send(0, empty_blk, 1, 1, 0);
        wait_pulses(0, base + 2);
        check(dig[0] == EMPTY_DIG, "back-to-back second digest", dig[0], EMPTY_DIG);

        base = pulse_cnt[0];
        send(0, abc_blk, 1, 1, 0);
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check(dig[0] == 160'd0, "digest after abort", dig[0], 160'd0);
        check(pulse_cnt[0] == base, "no pulse on abort", 160'(pulse_cnt[0]), 160'(base));
        @(posedge clk); #1;
        send(0, abc_blk, 1, 1, 0);
        wait_pulses(0, base + 1);
        check(dig[0] == ABC_DIG, "abc resend digest", dig[0], ABC_DIG);

        // Lanes 1 and 2 (4 and 20 rounds per clock)
        for (int ln = 1; ln < 3; ln++) begin
            send(ln, abc_blk, 1, 1, 0);
            wait_pulses(ln, 1);
            check(dig[ln] == ABC_DIG, $sformatf("abc digest lane%0d", ln), dig[ln], ABC_DIG);
            check(pulse_cyc[ln] - acc_cyc[ln] == ((ln == 1) ? 22 : 6),
                  $sformatf("abc latency lane%0d", ln), 160'(pulse_cyc[ln] - acc_cyc[ln]),
                  160'((ln == 1) ? 22 : 6));
            base = pulse_cnt[ln];
            send(ln, mb[0], 1, 0, 0);
            send(ln, mb[1], 0, 0, 0);
            send(ln, mb[2], 0, 1, 0);
            wait_pulses(ln, base + 1);
            repeat (4) @(posedge clk);
            #1;
            check(dig[ln] == mb_exp, $sformatf("multiblock digest lane%0d", ln), dig[ln], mb_exp);
            check(pulse_cnt[ln] == base + 1, $sformatf("multiblock pulse count lane%0d", ln),
                  160'(pulse_cnt[ln]), 160'(base + 1));
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
